fpu_rept: RTL and testbench



---
 rtl/fpu_rept.sv | 46 ++++
 tb/tb_fpu_rept.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fpu_rept.sv
// Rounder front-end: reduces a 128-bit normalized significand to the
// guard-extended significand at double/single precision plus a sticky bit.
module fpu_rept (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [127:0] fn,
  input  logic         db,
  output logic         out_valid,
  output logic [54:0]  f1
);

  logic        out_valid_q, out_valid_d;
  logic [54:0] f1_q, f1_d;
  logic        sticky_dbl, sticky_sgl;

  // Sticky gathers every bit below the guard position of the selected format.
  assign sticky_dbl = |fn[73:0];
  assign sticky_sgl = |fn[102:0];

  always_comb begin
    f1_d        = f1_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      if (db) begin
        f1_d = {fn[127:74], sticky_dbl};
      end else begin
        f1_d = {fn[127:103], sticky_sgl, 29'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      f1_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      f1_q        <= f1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign f1        = f1_q;

endmodule

// File: tb/tb_fpu_rept.sv
// Directed and back-to-back checks of fpu_rept via a one-cycle scoreboard.
module tb_fpu_rept;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] fn;
  logic         db;
  logic         out_valid;
  logic [54:0]  f1;

  typedef struct {
    logic        v;
    logic        chkf;
    logic [54:0] f;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  fpu_rept dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .fn        (fn),
    .db        (db),
    .out_valid (out_valid),
    .f1        (f1)
  );

  always #5 clk = ~clk;

  // Reference built from shifts rather than slices: low bits survive a left
  // shift that discards everything at or above the guard.
  function automatic logic [54:0] model(input logic [127:0] x, input logic d);
    logic [127:0] hi, lo;
    if (d) begin
      hi = x >> 74;
      lo = x << 54;
      return {hi[53:0], (lo != 0)};
    end else begin
      hi = x >> 103;
      lo = x << 25;
      return {hi[24:0], (lo != 0), 29'b0};
    end
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [127:0] x,
                     input logic d, input logic chkf, input logic [54:0] ef,
                     input string tag);
    exp_t e, p;
    rst      = r;
    in_valid = v;
    fn       = x;
    db       = d;
    e.v    = v && !r;
    e.chkf = chkf;
    e.f    = ef;
    e.tag  = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    p = exp_q.pop_front();
    total++;
    assert (out_valid === p.v) else begin
      bad++;
      $error("FAIL %s out_valid: got %0b want %0b", p.tag, out_valid, p.v);
    end
    if (p.chkf) begin
      total++;
      assert (f1 === p.f) else begin
        bad++;
        $error("FAIL %s f1: got %h want %h", p.tag, f1, p.f);
      end
    end
  endtask

  logic [127:0] ones;
  logic [127:0] rnd;
  logic         rdb;

  initial begin
    ones = '1;
    rst = 1'b1; in_valid = 1'b0; fn = '0; db = 1'b0;

    cyc(1'b1, 1'b1, ones, 1'b1, 1'b1, 55'h0, "rst0");
    cyc(1'b1, 1'b1, ones, 1'b0, 1'b1, 55'h0, "rst1");
    cyc(1'b0, 1'b0, ones, 1'b1, 1'b1, 55'h0, "idle0");
    cyc(1'b0, 1'b0, ones, 1'b0, 1'b1, 55'h0, "idle1");

    cyc(1'b0, 1'b1, 128'hA1B2C3D4E5F60789ABCDEF0123456789, 1'b1, 1'b1,
        55'h50D961EA72FB03, "dbl_mix");
    cyc(1'b0, 1'b1, 128'h1234567890ABCDEFFEDCBA0987654321, 1'b0, 1'b1,
        55'h0091A2B20000000, "sgl_mix");
    cyc(1'b0, 1'b1, 128'h1, 1'b1, 1'b1, 55'h1, "dbl_bit0");
    cyc(1'b0, 1'b1, 128'h1, 1'b0, 1'b1, 55'h1 << 29, "sgl_bit0");
    cyc(1'b0, 1'b1, 128'h1 << 74, 1'b1, 1'b1, 55'h2, "dbl_guard");
    cyc(1'b0, 1'b1, 128'h1 << 73, 1'b1, 1'b1, 55'h1, "dbl_b73");
    cyc(1'b0, 1'b1, 128'h1 << 103, 1'b0, 1'b1, 55'h1 << 30, "sgl_guard");
    cyc(1'b0, 1'b1, 128'h1 << 102, 1'b0, 1'b1, 55'h1 << 29, "sgl_b102");
    cyc(1'b0, 1'b1, 128'h0, 1'b1, 1'b1, 55'h0, "dbl_zero");
    cyc(1'b0, 1'b1, 128'h0, 1'b0, 1'b1, 55'h0, "sgl_zero");
    cyc(1'b0, 1'b1, ones, 1'b1, 1'b1, {55{1'b1}}, "dbl_ones");
    cyc(1'b0, 1'b1, ones, 1'b0, 1'b1, {{26{1'b1}}, 29'b0}, "sgl_ones");
    cyc(1'b0, 1'b1, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
        {1'b0, {54{1'b1}}}, "dbl_unnorm");

    // Back-to-back with alternating precision, then a bubble, then more.
    for (int i = 0; i < 12; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      rdb = i[0];
      cyc(1'b0, 1'b1, rnd, rdb, 1'b1, model(rnd, rdb), "b2b");
      if (i == 5) cyc(1'b0, 1'b0, ones, 1'b1, 1'b0, 55'h0, "bubble");
    end
    cyc(1'b0, 1'b0, ones, 1'b0, 1'b0, 55'h0, "tail_idle");

    // Operation sampled with reset is discarded.
    cyc(1'b1, 1'b1, ones, 1'b1, 1'b1, 55'h0, "rst_mid");
    cyc(1'b0, 1'b1, 128'h1 << 74, 1'b1, 1'b1, 55'h2, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
